// File: rtl/scan_sram_arb.sv
// Arbiter sharing one single-port SRAM macro between a scan/test port and a functional core port.
// Optional parity (bit 32 of memory data, sticky par_err) is built when SCAN_SRAM_PARITY_EN is defined.
module scan_sram_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        test_mode,
    input  logic        sram_ren,
    input  logic        sram_wen,
    input  logic [10:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        sram_ready,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [10:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [1:0]  dbg_state,
`ifdef SCAN_SRAM_PARITY_EN
    output logic [32:0] mem_wdata,
    input  logic [32:0] mem_rdata,
    output logic        par_err
`else
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`endif
);

    // Scan handshake: sram_ren/sram_wen are static levels. A level seen in IDLE starts
    // one access; sram_ready pulses once; the level must drop before another is taken.
    // Core handshake: core_gnt is combinational in the request cycle (core_req & core_gnt
    // = accepted); read data follows with core_rvalid in the next cycle.
    typedef enum logic [1:0] {IDLE, S_ACC, S_RSP, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [10:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        scan_req;
    logic        scan_rd_rsp;
    logic [31:0] wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        core_gnt    = 1'b0;
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = core_addr;
        wr_data     = core_wdata;
        sram_ready  = 1'b0;
        scan_rd_rsp = 1'b0;
        scan_req    = sram_ren | sram_wen;

        case (state_q)
            IDLE: begin
                if (test_mode) begin
                    if (scan_req) begin
                        state_d = S_ACC;
                        addr_d  = sram_addr;
                        wdata_d = sram_wdata;
                        we_d    = sram_wen;
                    end
                end else if (core_req) begin
                    core_gnt = 1'b1;
                    mem_ce   = 1'b1;
                    mem_we   = core_we;
                end
            end
            S_ACC: begin
                mem_ce   = 1'b1;
                mem_we   = we_q;
                mem_addr = addr_q;
                wr_data  = wdata_q;
                state_d  = S_RSP;
            end
            S_RSP: begin
                // Macro data is valid in this cycle; show it now and keep it for later reads.
                sram_ready  = 1'b1;
                scan_rd_rsp = ~we_q;
                if (!we_q) begin
                    rdata_d = mem_rdata[31:0];
                end
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!scan_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A reset cycle issues nothing, even from the middle of a scan sequence.
        if (rst) begin
            core_gnt    = 1'b0;
            mem_ce      = 1'b0;
            mem_we      = 1'b0;
            sram_ready  = 1'b0;
            scan_rd_rsp = 1'b0;
        end

        rvalid_d = core_gnt & ~core_we;
    end

    assign sram_rdata  = scan_rd_rsp ? mem_rdata[31:0] : rdata_q;
    assign core_rvalid = rvalid_q;
    assign core_rdata  = mem_rdata[31:0];
    assign dbg_state   = state_q;

`ifdef SCAN_SRAM_PARITY_EN
    logic par_err_q, par_err_d;

    always_comb begin
        par_err_d = par_err_q | ((scan_rd_rsp | rvalid_q) & (^mem_rdata));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign mem_wdata = {^wr_data, wr_data};
    assign par_err   = par_err_q;
`else
    assign mem_wdata = wr_data;
`endif

endmodule

// File: tb/tb_scan_sram_arb.sv
// Bench for scan_sram_arb: table vectors, directed scan/core/reset sequences, and random
// traffic checked against an array memory model and an expected-read queue.
module tb_scan_sram_arb;
`ifdef SCAN_SRAM_PARITY_EN
    localparam int MW = 33;
`else
    localparam int MW = 32;
`endif

    logic          clk, rst, test_mode, sram_ren, sram_wen;
    logic [10:0]   sram_addr;
    logic [31:0]   sram_wdata, sram_rdata;
    logic          sram_ready, core_req, core_we, core_gnt, core_rvalid;
    logic [10:0]   core_addr;
    logic [31:0]   core_wdata, core_rdata;
    logic          mem_ce, mem_we;
    logic [10:0]   mem_addr;
    logic [1:0]    dbg_state;
    logic [MW-1:0] mem_wdata, mem_rdata;
`ifdef SCAN_SRAM_PARITY_EN
    logic          par_err;
`endif

    scan_sram_arb dut (
        .clk(clk), .rst(rst), .test_mode(test_mode),
        .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_addr(mem_addr), .dbg_state(dbg_state),
`ifdef SCAN_SRAM_PARITY_EN
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .par_err(par_err)
`else
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // SRAM macro model: registered read, data valid the cycle after mem_ce
    logic [MW-1:0] mem [2048];
    logic [MW-1:0] rd_q;
    logic          flip_par;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        rd_q     = '0;
        flip_par = 1'b0;
    end

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        rd_q <= mem[mem_addr];
        end
    end

`ifdef SCAN_SRAM_PARITY_EN
    assign mem_rdata = rd_q ^ {flip_par, 32'h0};
`else
    assign mem_rdata = rd_q;
`endif

    // scoreboard
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [2048];
    logic [31:0] exp_q[$];
    logic [31:0] last_scan_rd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // drivers: all start and end at posedge+1
    task automatic core_op(input logic req, input logic we, input logic [10:0] a, input logic [31:0] d);
        test_mode = 1'b0; core_req = req; core_we = we; core_addr = a; core_wdata = d;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            chk("core_rvalid", {63'h0, core_rvalid}, 64'h1);
            chk("core_rdata", {32'h0, core_rdata}, {32'h0, exp_q.pop_front()});
        end else begin
            chk("core_rvalid_idle", {63'h0, core_rvalid}, 64'h0);
        end
        chk("core_gnt", {63'h0, core_gnt}, {63'h0, req});
        chk("core_mem_ce", {63'h0, mem_ce}, {63'h0, req});
        if (req) begin
            chk("core_mem_we", {63'h0, mem_we}, {63'h0, we});
            chk("core_mem_addr", {53'h0, mem_addr}, {53'h0, a});
            if (we) begin
                chk("core_mem_wdata", {32'h0, mem_wdata[31:0]}, {32'h0, d});
                ref_mem[a] = d;
            end else begin
                exp_q.push_back(ref_mem[a]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic scan_txn(input logic ren, input logic wen, input logic [10:0] a, input logic [31:0] d);
        int          ready_at;
        int          ready_n;
        int          ce_n;
        logic [31:0] exp_rd;
        ready_at = -1; ready_n = 0; ce_n = 0;
        exp_rd = wen ? last_scan_rd : ref_mem[a];
        test_mode = 1'b1; sram_ren = ren; sram_wen = wen; sram_addr = a; sram_wdata = d;
        for (int c = 1; c <= 6; c++) begin
            core_req  = 1'($urandom_range(0, 1));
            core_we   = 1'($urandom_range(0, 1));
            core_addr = 11'($urandom_range(0, 2047));
            @(posedge clk);
            @(negedge clk);
            chk("scan_core_gnt", {63'h0, core_gnt}, 64'h0);
            if (mem_ce) begin
                ce_n++;
                if (c == 1) begin
                    chk("scan_mem_we", {63'h0, mem_we}, {63'h0, wen});
                    chk("scan_mem_addr", {53'h0, mem_addr}, {53'h0, a});
                    if (wen) chk("scan_mem_wdata", {32'h0, mem_wdata[31:0]}, {32'h0, d});
`ifdef SCAN_SRAM_PARITY_EN
                    if (wen) chk("scan_mem_wpar", {63'h0, mem_wdata[32]}, {63'h0, ^d});
`endif
                end
            end
            if (sram_ready) begin
                ready_n++;
                if (ready_at < 0) ready_at = c;
                chk("sram_rdata_rsp", {32'h0, sram_rdata}, {32'h0, exp_rd});
            end
        end
        chk("scan_ce_count", 64'(ce_n), 64'd1);
        chk("scan_ready_count", 64'(ready_n), 64'd1);
        chk("scan_ready_cycle", 64'(ready_at), 64'd2);
        if (wen) ref_mem[a] = d;
        else     last_scan_rd = exp_rd;
        sram_ren = 1'b0; sram_wen = 1'b0; core_req = 1'b0;
        @(posedge clk); #1;
        chk("sram_rdata_hold", {32'h0, sram_rdata}, {32'h0, last_scan_rd});
    endtask

    typedef struct {
        logic        tm;
        logic        req;
        logic        we;
        logic [10:0] addr;
        logic [31:0] wd;
        logic        exp_gnt;
    } vec_t;

    vec_t        tbl [6];
    logic        prev_rd;
    logic [31:0] prev_data;
    logic [10:0] ra;
    int          kind;
    int          nb;

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
        last_scan_rd = '0;
        rst = 1'b1; test_mode = 1'b0; sram_ren = 1'b0; sram_wen = 1'b0;
        sram_addr = '0; sram_wdata = '0;
        core_req = 1'b1; core_we = 1'b0; core_addr = '0; core_wdata = '0;

        // reset state, with a core request pending to check gating
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_core_gnt", {63'h0, core_gnt}, 64'h0);
        chk("rst_mem_ce", {63'h0, mem_ce}, 64'h0);
        chk("rst_mem_we", {63'h0, mem_we}, 64'h0);
        chk("rst_sram_ready", {63'h0, sram_ready}, 64'h0);
        chk("rst_core_rvalid", {63'h0, core_rvalid}, 64'h0);
        chk("rst_sram_rdata", {32'h0, sram_rdata}, 64'h0);
`ifdef SCAN_SRAM_PARITY_EN
        chk("rst_par_err", {63'h0, par_err}, 64'h0);
`endif
        @(posedge clk); #1;
        rst = 1'b0; core_req = 1'b0;

        // table-driven IDLE arbitration vectors
        tbl[0] = '{1'b0, 1'b1, 1'b0, 11'h000, 32'h0,         1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 11'h7F0, 32'h12345678,  1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 11'h001, 32'h0,         1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 11'h7F1, 32'hFFFF0000,  1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 11'h7F2, 32'h55AA55AA,  1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 11'h7FF, 32'hA5A5A5A5,  1'b1};
        prev_rd = 1'b0; prev_data = '0;
        for (int i = 0; i < 6; i++) begin
            test_mode = tbl[i].tm; core_req = tbl[i].req; core_we = tbl[i].we;
            core_addr = tbl[i].addr; core_wdata = tbl[i].wd;
            @(negedge clk);
            chk("tbl_gnt", {63'h0, core_gnt}, {63'h0, tbl[i].exp_gnt});
            chk("tbl_ce", {63'h0, mem_ce}, {63'h0, tbl[i].exp_gnt});
            chk("tbl_we", {63'h0, mem_we}, {63'h0, tbl[i].exp_gnt & tbl[i].we});
            if (tbl[i].exp_gnt) chk("tbl_addr", {53'h0, mem_addr}, {53'h0, tbl[i].addr});
            chk("tbl_rvalid", {63'h0, core_rvalid}, {63'h0, prev_rd});
            if (prev_rd) chk("tbl_rdata", {32'h0, core_rdata}, {32'h0, prev_data});
            prev_data = ref_mem[tbl[i].addr];
            prev_rd   = tbl[i].exp_gnt & ~tbl[i].we;
            if (tbl[i].exp_gnt & tbl[i].we) ref_mem[tbl[i].addr] = tbl[i].wd;
            @(posedge clk); #1;
        end
        core_req = 1'b0;

        // scan write then read of 0x155
        scan_txn(1'b0, 1'b1, 11'h155, 32'hDEADBEEF);
        scan_txn(1'b1, 1'b0, 11'h155, 32'h0);
        chk("scan_read_155", {32'h0, sram_rdata}, 64'hDEADBEEF);
        // both levels high: write only, read data untouched
        scan_txn(1'b1, 1'b1, 11'h156, 32'hCAFEF00D);

        // core back-to-back reads of 0x000..0x003
        for (int i = 0; i < 4; i++) core_op(1'b1, 1'b1, 11'(i), 32'h1000 + 32'(i));
        for (int i = 0; i < 4; i++) core_op(1'b1, 1'b0, 11'(i), 32'h0);
        core_op(1'b0, 1'b0, 11'h0, 32'h0);

        // test_mode falls while the scan access is in flight
        test_mode = 1'b1; sram_ren = 1'b1; sram_wen = 1'b0; sram_addr = 11'h155;
        core_req = 1'b1; core_we = 1'b0; core_addr = 11'h003;
        @(negedge clk);
        chk("tm_core_blocked_gnt", {63'h0, core_gnt}, 64'h0);
        chk("tm_core_blocked_ce", {63'h0, mem_ce}, 64'h0);
        @(posedge clk); #1;
        test_mode = 1'b0;
        @(negedge clk);
        chk("tmfall_acc_gnt", {63'h0, core_gnt}, 64'h0);
        chk("tmfall_acc_ce", {63'h0, mem_ce}, 64'h1);
        chk("tmfall_acc_addr", {53'h0, mem_addr}, 64'h155);
        @(posedge clk); @(negedge clk);
        chk("tmfall_ready", {63'h0, sram_ready}, 64'h1);
        chk("tmfall_rdata", {32'h0, sram_rdata}, {32'h0, ref_mem[11'h155]});
        chk("tmfall_rsp_gnt", {63'h0, core_gnt}, 64'h0);
        @(posedge clk); @(negedge clk);
        chk("tmfall_hold_gnt", {63'h0, core_gnt}, 64'h0);
        chk("tmfall_hold_ce", {63'h0, mem_ce}, 64'h0);
        chk("tmfall_hold_ready", {63'h0, sram_ready}, 64'h0);
        last_scan_rd = ref_mem[11'h155];
        sram_ren = 1'b0;
        @(posedge clk); #1;
        core_op(1'b1, 1'b0, 11'h003, 32'h0);
        core_op(1'b0, 1'b0, 11'h0, 32'h0);

        // reset while in S_ACC abandons the access; the held level is served once afterwards
        test_mode = 1'b1; sram_wen = 1'b1; sram_ren = 1'b0;
        sram_addr = 11'h2AA; sram_wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_acc_ce", {63'h0, mem_ce}, 64'h0);
        chk("rst_acc_ready", {63'h0, sram_ready}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_scan_rd = '0;
        chk("rst_acc_rdata_clr", {32'h0, sram_rdata}, 64'h0);
        scan_txn(1'b0, 1'b1, 11'h2AA, 32'h0BADF00D);

        // random mixed traffic against the array model
        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) ra = 11'($urandom_range(0, 2047));
            else                           ra = 11'($urandom_range(0, 15));
            case (kind)
                0, 1: begin
                    nb = $urandom_range(1, 5);
                    for (int j = 0; j < nb; j++) begin
                        core_op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                                11'($urandom_range(0, 15)), $urandom());
                    end
                    core_op(1'b0, 1'b0, 11'h0, 32'h0);
                end
                2: scan_txn(1'($urandom_range(0, 3) == 0), 1'b1, ra, $urandom());
                default: scan_txn(1'b1, 1'b0, ra, 32'h0);
            endcase
        end

`ifdef SCAN_SRAM_PARITY_EN
        chk("par_err_clean", {63'h0, par_err}, 64'h0);
        scan_txn(1'b0, 1'b1, 11'h0A0, 32'h13572468);
        flip_par = 1'b1;
        scan_txn(1'b1, 1'b0, 11'h0A0, 32'h0);
        flip_par = 1'b0;
        chk("par_err_set", {63'h0, par_err}, 64'h1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("par_err_sticky", {63'h0, par_err}, 64'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("par_err_rst", {63'h0, par_err}, 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
